// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: a WIDTH-bit carry chain resolved CHUNK bits per stage,
// with a per-stage valid/ready handshake so bubbles collapse under backpressure.
module pipelined_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;

    // Stage registers: operands travel with the beat so later chunks and the
    // final overflow test see the same (preprocessed) values.
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] sub_q;
    logic [WIDTH-1:0]  xa_q [STAGES];
    logic [WIDTH-1:0]  yb_q [STAGES];
    logic [WIDTH-1:0]  s_q  [STAGES];

    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] sub_in;
    logic [STAGES-1:0] c_d;
    logic [WIDTH-1:0]  xa_in [STAGES];
    logic [WIDTH-1:0]  yb_in [STAGES];
    logic [WIDTH-1:0]  s_in  [STAGES];
    logic [WIDTH-1:0]  s_d   [STAGES];

    // A stage may load when it is empty or the stage after it is moving.
    always_comb begin : ready_chain
        logic acc;
        rdy = '0;
        acc = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc    = !v_q[k] || acc;
            rdy[k] = acc;
        end
    end

    always_comb begin : stage_logic
        logic [CHUNK:0] part;
        part = '0;
        v_in   = '0;
        c_in   = '0;
        sub_in = '0;
        c_d    = '0;
        for (int k = 0; k < STAGES; k++) begin
            xa_in[k] = '0;
            yb_in[k] = '0;
            s_in[k]  = '0;
            s_d[k]   = '0;
        end

        // Subtraction is x + ~y + ~cin, so B and the carry-in are inverted at entry.
        v_in[0]   = in_valid;
        xa_in[0]  = x;
        yb_in[0]  = sub ? ~y : y;
        c_in[0]   = sub ^ cin;
        sub_in[0] = sub;

        for (int k = 1; k < STAGES; k++) begin
            v_in[k]   = v_q[k-1];
            xa_in[k]  = xa_q[k-1];
            yb_in[k]  = yb_q[k-1];
            c_in[k]   = c_q[k-1];
            sub_in[k] = sub_q[k-1];
            s_in[k]   = s_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            part = {1'b0, xa_in[k][k*CHUNK +: CHUNK]}
                 + {1'b0, yb_in[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, c_in[k]};
            s_d[k]                   = s_in[k];
            s_d[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
            c_d[k]                   = part[CHUNK];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            sub_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                xa_q[k] <= '0;
                yb_q[k] <= '0;
                s_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v_q[k]   <= v_in[k];
                    c_q[k]   <= c_d[k];
                    sub_q[k] <= sub_in[k];
                    xa_q[k]  <= xa_in[k];
                    yb_q[k]  <= yb_in[k];
                    s_q[k]   <= s_d[k];
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = sub_q[STAGES-1] ? ~c_q[STAGES-1] : c_q[STAGES-1];
    assign ovf       = (xa_q[STAGES-1][WIDTH-1] == yb_q[STAGES-1][WIDTH-1])
                    && (s_q[STAGES-1][WIDTH-1] != xa_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: expected results are queued on accept and
// compared, in order, on delivery; also checks stall stability, in_ready and latency.
module tb_pipelined_adder;

    localparam int W      = 32;
    localparam int C      = 8;
    localparam int STAGES = W / C;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    typedef struct {
        logic [W+1:0] val;
        int           accept_at;
    } beat_t;

    beat_t        sb_q[$];
    int           compare_count  = 0;
    int           mismatch_count = 0;
    int           neg_count      = 0;
    bit           check_latency  = 1'b1;
    bit           random_ready   = 1'b0;
    bit           stall_prev     = 1'b0;
    logic [W+2:0] prev_out;

    pipelined_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain wide arithmetic, result packed as {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic sb);
        logic [W:0]   full;
        logic [W-1:0] s;
        logic         v;
        if (!sb) begin
            full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            s    = full[W-1:0];
            v    = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, ci};
            s    = full[W-1:0];
            v    = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end
        return {v, full[W], s};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Called at posedge+1; presents one beat and returns at posedge+1 after it is taken.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sb);
        bit taken;
        x        = a;
        y        = b;
        cin      = ci;
        sub      = sb;
        in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            taken = in_ready && rst_n;
            @(posedge clk);
            #1;
            if (taken) break;
            if (i == 999) checkOutput("accept_timeout", 64'd1, 64'd0);
        end
        in_valid = 1'b0;
        x        = $urandom;
        y        = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && sb_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drain_left", 64'(sb_q.size()), 64'd0);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (random_ready) out_ready = $urandom_range(0, 1) != 0;
    end

    // Monitor: all handshake decisions are taken mid-cycle, away from the edge.
    always @(negedge clk) begin
        beat_t e;
        neg_count++;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            checkOutput("in_ready", {63'd0, in_ready},
                        (sb_q.size() == STAGES && !out_ready) ? 64'd0 : 64'd1);
            if (stall_prev)
                checkOutput("stall_stable", 64'({out_valid, ovf, cout, sum}), 64'(prev_out));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checkOutput("spurious_out", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("result", 64'({ovf, cout, sum}), 64'(e.val));
                    if (check_latency)
                        checkOutput("latency", 64'(neg_count - e.accept_at), 64'(STAGES));
                end
            end
            if (in_valid && in_ready) begin
                e.val       = model(x, y, cin, sub);
                e.accept_at = neg_count;
                sb_q.push_back(e);
            end
            stall_prev = out_valid && !out_ready;
            prev_out   = {out_valid, ovf, cout, sum};
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cin       = 1'b0;
        sub       = 1'b0;

        // Held in reset with live random inputs: nothing may come out.
        for (int i = 0; i < 3; i++) begin
            x   = $urandom;
            y   = $urandom;
            cin = 1'($urandom);
            sub = 1'($urandom);
            @(negedge clk);
            checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
            checkOutput("reset_sum", 64'(sum), 64'd0);
            checkOutput("reset_cout_ovf", {62'd0, cout, ovf}, 64'd0);
            checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed beats with an always-ready consumer, so latency must be exact.
        applyStimulus(32'd1, 32'd2, 1'b0, 1'b0);
        drain();
        applyStimulus(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        applyStimulus(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        applyStimulus(32'd5, 32'd7, 1'b0, 1'b1);
        applyStimulus(32'h8000_0000, 32'd1, 1'b0, 1'b1);
        applyStimulus(32'd10, 32'd3, 1'b1, 1'b1);
        applyStimulus(32'd0, 32'd1, 1'b0, 1'b1);
        applyStimulus(32'd0, 32'd0, 1'b1, 1'b1);
        drain();

        // Random stream against a randomly stalling consumer.
        check_latency = 1'b0;
        random_ready  = 1'b1;
        for (int i = 0; i < 200; i++)
            applyStimulus($urandom, $urandom, 1'($urandom), 1'($urandom));
        random_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Reset with three beats in flight and the oldest stalled at the output.
        out_ready = 1'b0;
        applyStimulus(32'd100, 32'd200, 1'b0, 1'b0);
        applyStimulus(32'd300, 32'd400, 1'b0, 1'b0);
        applyStimulus(32'd500, 32'd600, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_async_valid", {63'd0, out_valid}, 64'd0);
        sb_q.delete();
        #3;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_latency = 1'b1;
        applyStimulus(32'h1234_5678, 32'h0101_0101, 1'b0, 1'b0);
        drain();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
